// File: rtl/rf_bank_arbiter_pkg.sv
// Shared sizes, id types and operand tag encodings for the RF bank arbiter.
package gpgpu_rf_pkg;
  localparam int NUM_OC   = 4;
  localparam int NUM_BANK = 4;
  localparam int ROW_W    = 3;
  localparam int DATA_W   = 256;

  typedef logic [1:0]       oc_id_t;
  typedef logic [1:0]       bank_id_t;
  typedef logic [ROW_W-1:0] row_t;

  localparam logic OPND_SRC1 = 1'b0;
  localparam logic OPND_SRC2 = 1'b1;
endpackage

// File: rtl/rf_bank_arbiter_if.sv
// Bundle of OC request/response, CDB write notice and RF bank read signals.
interface rf_bank_arbiter_if;
  import gpgpu_rf_pkg::*;

  logic [NUM_OC-1:0]          req_valid_oc;
  logic [2*NUM_OC-1:0]        req_bank_oc;
  logic [ROW_W*NUM_OC-1:0]    req_row_oc;
  logic [NUM_OC-1:0]          req_opnd_oc;
  logic [NUM_OC-1:0]          req_ready_oc;
  logic                       wr_pending_cdb;
  logic [1:0]                 wr_bank_cdb;
  logic [NUM_BANK-1:0]        rd_en_rf;
  logic [ROW_W*NUM_BANK-1:0]  rd_row_rf;
  logic [DATA_W*NUM_BANK-1:0] rd_data_rf;
  logic [NUM_OC-1:0]          rsp_valid_oc;
  logic [NUM_OC-1:0]          rsp_opnd_oc;
  logic [DATA_W*NUM_OC-1:0]   rsp_data_oc;

  modport master (
    output req_valid_oc, req_bank_oc, req_row_oc, req_opnd_oc,
           wr_pending_cdb, wr_bank_cdb, rd_data_rf,
    input  req_ready_oc, rd_en_rf, rd_row_rf,
           rsp_valid_oc, rsp_opnd_oc, rsp_data_oc
  );

  modport slave (
    input  req_valid_oc, req_bank_oc, req_row_oc, req_opnd_oc,
           wr_pending_cdb, wr_bank_cdb, rd_data_rf,
    output req_ready_oc, rd_en_rf, rd_row_rf,
           rsp_valid_oc, rsp_opnd_oc, rsp_data_oc
  );
endinterface

// File: rtl/rf_bank_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves just past the winner and holds when idle.
module rr_arbiter
  import gpgpu_rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_OC-1:0] req,
  output logic [NUM_OC-1:0] gnt
);
  oc_id_t ptr_reg, ptr_next;
  oc_id_t idx;
  logic   found;

  // oc_id_t is exactly log2(NUM_OC) wide, so its natural wrap is the modulo.
  always_comb begin
    gnt      = '0;
    found    = 1'b0;
    ptr_next = ptr_reg;
    idx      = '0;
    for (int i = 0; i < NUM_OC; i++) begin
      idx = ptr_reg + oc_id_t'(i);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
        ptr_next = idx + oc_id_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_reg <= '0;
    else      ptr_reg <= ptr_next;
  end
endmodule

// File: rtl/rf_bank_arbiter.sv
// Per-bank round-robin sharing of the RF read ports among the operand collectors,
// 3-cycle grant-to-response pipeline. Option RF_BANK_CONFLICT_CNT_EN adds conflict_cnt.
module rf_bank_arbiter
  import gpgpu_rf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  rf_bank_arbiter_if.slave bus
`ifdef RF_BANK_CONFLICT_CNT_EN
  ,
  output logic [15:0]      conflict_cnt
`endif
);
  logic [NUM_BANK-1:0][NUM_OC-1:0] gnt_all;
  logic [NUM_BANK-1:0]             s2_valid;
  logic [NUM_BANK-1:0]             s2_opnd;
  oc_id_t                          s2_oc [NUM_BANK];
  logic [NUM_OC-1:0]               ready;
  logic [NUM_OC-1:0]               rsp_valid_reg;
  logic [NUM_OC-1:0]               rsp_opnd_reg;
  logic [DATA_W*NUM_OC-1:0]        rsp_data_reg;

  for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_bank
    logic [NUM_OC-1:0] req_vec;
    oc_id_t            win_id;
    logic              s1_valid_reg, s2_valid_reg;
    oc_id_t            s1_oc_reg, s2_oc_reg;
    logic              s1_opnd_reg, s2_opnd_reg;
    row_t              row_reg;

    // A pending CDB write owns the bank outright; masking the requests also
    // keeps the pointer from moving.
    always_comb begin
      req_vec = '0;
      for (int i = 0; i < NUM_OC; i++)
        req_vec[i] = rst && bus.req_valid_oc[i] &&
                     (bus.req_bank_oc[2*i +: 2] == bank_id_t'(gi));
      if (bus.wr_pending_cdb && (bus.wr_bank_cdb == bank_id_t'(gi)))
        req_vec = '0;
    end

    rr_arbiter u_rr (
      .clk (clk),
      .rst (rst),
      .req (req_vec),
      .gnt (gnt_all[gi])
    );

    always_comb begin
      win_id = '0;
      for (int i = 0; i < NUM_OC; i++)
        if (gnt_all[gi][i]) win_id = oc_id_t'(i);
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        s1_valid_reg <= 1'b0;
        s1_oc_reg    <= '0;
        s1_opnd_reg  <= 1'b0;
        row_reg      <= '0;
        s2_valid_reg <= 1'b0;
        s2_oc_reg    <= '0;
        s2_opnd_reg  <= 1'b0;
      end else begin
        s1_valid_reg <= |gnt_all[gi];
        s1_oc_reg    <= win_id;
        s1_opnd_reg  <= bus.req_opnd_oc[win_id];
        if (|gnt_all[gi]) row_reg <= bus.req_row_oc[ROW_W*win_id +: ROW_W];
        s2_valid_reg <= s1_valid_reg;
        s2_oc_reg    <= s1_oc_reg;
        s2_opnd_reg  <= s1_opnd_reg;
      end
    end

    assign bus.rd_en_rf[gi]                  = s1_valid_reg;
    assign bus.rd_row_rf[ROW_W*gi +: ROW_W]  = row_reg;
    assign s2_valid[gi]                      = s2_valid_reg;
    assign s2_oc[gi]                         = s2_oc_reg;
    assign s2_opnd[gi]                       = s2_opnd_reg;
  end

  // Each OC targets a single bank, so at most one bank grants any given OC.
  always_comb begin
    ready = '0;
    for (int b = 0; b < NUM_BANK; b++) ready = ready | gnt_all[b];
  end
  assign bus.req_ready_oc = ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid_reg <= '0;
      rsp_opnd_reg  <= {NUM_OC{OPND_SRC1}};
      rsp_data_reg  <= '0;
    end else begin
      rsp_valid_reg <= '0;
      for (int b = 0; b < NUM_BANK; b++) begin
        if (s2_valid[b]) begin
          rsp_valid_reg[s2_oc[b]]                   <= 1'b1;
          rsp_opnd_reg[s2_oc[b]]                    <= s2_opnd[b];
          rsp_data_reg[DATA_W*s2_oc[b] +: DATA_W]   <= bus.rd_data_rf[DATA_W*b +: DATA_W];
        end
      end
    end
  end

  assign bus.rsp_valid_oc = rsp_valid_reg;
  assign bus.rsp_opnd_oc  = rsp_opnd_reg;
  assign bus.rsp_data_oc  = rsp_data_reg;

`ifdef RF_BANK_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst)
      conflict_cnt_reg <= '0;
    else if ((|(bus.req_valid_oc & ~ready)) && (conflict_cnt_reg != 16'hFFFF))
      conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
  end
  assign conflict_cnt = conflict_cnt_reg;
`endif
endmodule
